// File: rtl/bit_matrix_transposer.sv
// Corner-turn: N rows in, N transposed columns out (column c bit r = row r bit c); `BIT_MATRIX_TRANSPOSER_PINGPONG_EN selects two banks.
// Latency: column 0 is valid the cycle after row N-1 is accepted; out_col/out_last hold while stalled.
// Backpressure: in_ready low while the write bank is full; out_valid/in_ready come only from registered state.
module bit_matrix_transposer #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_row,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_col,
  output logic         out_last
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign out_last = out_valid && (rd_idx == LAST);

`ifdef BIT_MATRIX_TRANSPOSER_PINGPONG_EN

  logic [N-1:0] bank [2][N];
  logic [1:0]   full;
  logic         wr_bank;
  logic         rd_bank;
  logic         wr_fire;
  logic         rd_fire;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // A bank cannot be both filling and draining, so the two halves never touch the same flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N; r++)
          bank[b][r] <= '0;
    end else begin
      if (wr_fire) begin
        bank[wr_bank][wr_idx] <= in_row;
        if (wr_idx == LAST) begin
          wr_idx        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_idx == LAST) begin
          rd_idx        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_col = '0;
    for (int r = 0; r < N; r++)
      out_col[r] = bank[rd_bank][r][rd_idx];
  end

`else

  typedef enum logic {FILL, DRAIN} state_t;

  state_t       state;
  logic [N-1:0] bank [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      for (int r = 0; r < N; r++)
        bank[r] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            bank[wr_idx] <= in_row;
            if (wr_idx == LAST) begin
              wr_idx    <= '0;
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST) begin
              rd_idx    <= '0;
              state     <= FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    out_col = '0;
    for (int r = 0; r < N; r++)
      out_col[r] = bank[r][rd_idx];
  end

`endif

endmodule

// File: tb/tb_bit_matrix_transposer.sv
// Directed bench for bit_matrix_transposer at N = 5; inputs driven and outputs sampled on the falling edge.
module tb_bit_matrix_transposer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_row = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_col;
  logic       out_last;

  int checks = 0;
  int failures = 0;

  logic [4:0] ident     [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  logic [4:0] dense_rows[5] = '{5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
  logic [4:0] dense_cols[5] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
  logic [4:0] alt_rows  [5] = '{5'b10101, 5'b10101, 5'b10101, 5'b10101, 5'b10101};
  logic [4:0] alt_cols  [5] = '{5'b11111, 5'b00000, 5'b11111, 5'b00000, 5'b11111};
  logic [4:0] mix_rows  [5] = '{5'b10011, 5'b01010, 5'b11100, 5'b00111, 5'b01001};
  logic [4:0] mix_cols  [5] = '{5'b11001, 5'b01011, 5'b01100, 5'b10110, 5'b00101};

  always #5 clk = ~clk;

  bit_matrix_transposer #(.N(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after row 4 is accepted.
  task automatic push(input logic [4:0] rows [5], input string tag);
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < 5 && guard < 40) begin
      in_valid = 1'b1;
      in_row   = rows[i];
      acc      = in_ready;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_row   = '0;
    if (i < 5) check({tag, "_push_timeout"}, i, 5);
  endtask

  task automatic drain(input logic [4:0] exp [5], input int first, input int cnt, input string tag);
    int k = first;
    int guard = 0;
    while (k < first + cnt && guard < 40) begin
      out_ready = 1'b1;
      if (out_valid) begin
        check($sformatf("%s_col%0d", tag, k), out_col, exp[k]);
        check($sformatf("%s_last%0d", tag, k), out_last, (k == 4));
        k++;
      end
      guard++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (k < first + cnt) check({tag, "_drain_timeout"}, k, first + cnt);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_col", out_col, 0);
    reset = 1'b0;

    // Identity, with latency check right after the fifth row.
    push(ident, "id");
    check("id_latency_valid", out_valid, 1);
    drain(ident, 0, 5, "id");
    check("id_idle_valid", out_valid, 0);

    push(dense_rows, "dense");
    drain(dense_cols, 0, 5, "dense");
    push(alt_rows, "alt");
    drain(alt_cols, 0, 5, "alt");

    // Stall three cycles on column 2.
    push(mix_rows, "bp");
    drain(mix_cols, 0, 2, "bp");
    for (int s = 0; s < 3; s++) begin
      out_ready = 1'b0;
      check($sformatf("bp_stall_valid%0d", s), out_valid, 1);
      check($sformatf("bp_stall_col%0d", s), out_col, mix_cols[2]);
      check($sformatf("bp_stall_last%0d", s), out_last, 0);
      @(negedge clk);
    end
    drain(mix_cols, 2, 3, "bp");

`ifdef BIT_MATRIX_TRANSPOSER_PINGPONG_EN
    begin
      logic [4:0] rows10[10];
      logic [4:0] cols10[10];
      int i = 0;
      int k = 0;
      for (int j = 0; j < 5; j++) begin
        rows10[j]     = ident[j];
        rows10[j + 5] = alt_rows[j];
        cols10[j]     = ident[j];
        cols10[j + 5] = alt_cols[j];
      end
      for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
        out_ready = 1'b1;
        if (i < 10) begin
          in_valid = 1'b1;
          in_row   = rows10[i];
          check($sformatf("pp_in_ready%0d", i), in_ready, 1);
          if (in_ready) i++;
        end else begin
          in_valid = 1'b0;
          in_row   = '0;
        end
        if (out_valid) begin
          check($sformatf("pp_col%0d", k), out_col, cols10[k]);
          check($sformatf("pp_last%0d", k), out_last, (k == 4 || k == 9));
          k++;
        end
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (k < 10) check("pp_drain_timeout", k, 10);
    end
`else
    begin
      int zeros = 0;
      push(ident, "tp");
      out_ready = 1'b1;
      for (int g = 0; g < 20 && !in_ready; g++) begin
        zeros++;
        @(negedge clk);
      end
      out_ready = 1'b0;
      check("tp_blocked_cycles", zeros, 5);
      check("tp_after_valid", out_valid, 0);
    end
`endif

    // Reset after two columns drained; partial matrix must vanish.
    push(mix_rows, "rst");
    drain(mix_cols, 0, 2, "rst");
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_last", out_last, 0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_no_stale", out_valid, 0);
    push(ident, "rid");
    drain(ident, 0, 5, "rid");
    check("rid_idle_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
